fetch_queue: RTL and testbench

- Fetch stage directly upstream of decode.
- Generates the sequential PC, issues word reads to a fixed-latency instruction memory, and buffers returned words in a small queue.
- Presents PC/instruction pairs to decode with a valid/ready handshake.
- Accepts redirects from decode (next_PC_select/target_PC) and flushes stale fetches.

---
 rtl/fetch_queue_if.sv | 25 ++
 rtl/fetch_queue.sv | 90 +++++++++
 tb/tb_fetch_queue.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch <-> decode / instruction-memory signal bundle.
// master: the fetch queue itself; slave: decode plus instruction memory.
interface fetch_queue_if #(
    parameter int ADDRESS_BITS = 16
);
    logic                    next_PC_select;
    logic [ADDRESS_BITS-1:0] target_PC;
    logic                    inst_ready;
    logic                    imem_req;
    logic [ADDRESS_BITS-1:0] imem_addr;
    logic [31:0]             imem_rdata;
    logic [ADDRESS_BITS-1:0] PC;
    logic [31:0]             instruction;
    logic                    inst_valid;

    modport master (
        input  next_PC_select, target_PC, inst_ready, imem_rdata,
        output imem_req, imem_addr, PC, instruction, inst_valid
    );

    modport slave (
        output next_PC_select, target_PC, inst_ready, imem_rdata,
        input  imem_req, imem_addr, PC, instruction, inst_valid
    );
endinterface

// File: rtl/fetch_queue.sv
// Fetch stage: sequential PC generation, fixed one-cycle-latency imem reads,
// a small circular instruction queue towards decode, and redirect flushing.
module fetch_queue #(
    parameter int                        ADDRESS_BITS = 16,
    parameter logic [ADDRESS_BITS-1:0]   RESET_PC     = '0,
    parameter int                        DEPTH        = 2,
    parameter logic [31:0]               NOP          = 32'h00000013
) (
    input  logic          clock,
    input  logic          reset,
    fetch_queue_if.master bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDRESS_BITS-1:0] r_fetch_pc;
    logic [ADDRESS_BITS-1:0] r_tag;
    logic                    r_inflight;
    logic                    r_run;
    logic [PW-1:0]           r_head;
    logic [PW-1:0]           r_tail;
    logic [CW-1:0]           r_count;
    logic [ADDRESS_BITS-1:0] r_q_pc   [DEPTH];
    logic [31:0]             r_q_inst [DEPTH];

    logic                    w_redirect;
    logic                    w_valid;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_issue;
    logic [CW:0]             w_occ;
    logic [ADDRESS_BITS-1:0] w_target;

    assign w_redirect = bus.next_PC_select;
    assign w_target   = bus.target_PC & ~ADDRESS_BITS'(3);
    assign w_valid    = (r_count != '0);
    assign w_pop      = w_valid & bus.inst_ready;
    // The returning word lands in the slot its issue reserved.
    assign w_push     = r_inflight & ~w_redirect;
    // Slots already claimed after this edge's pop; issue only if one is free.
    assign w_occ      = {1'b0, r_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
    // r_run holds off the first request until one edge after reset release.
    assign w_issue    = r_run & ~w_redirect & (w_occ < (CW+1)'(DEPTH));

    assign bus.imem_req    = w_issue;
    assign bus.imem_addr   = r_fetch_pc;
    assign bus.inst_valid  = w_valid;
    assign bus.PC          = w_valid ? r_q_pc[r_head]   : '0;
    assign bus.instruction = w_valid ? r_q_inst[r_head] : NOP;

    // Fetch PC, in-flight tracking and queue pointers; redirect beats everything.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
            r_tag      <= RESET_PC;
            r_inflight <= 1'b0;
            r_run      <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_redirect) begin
                r_fetch_pc <= w_target;
                r_inflight <= 1'b0;
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + ADDRESS_BITS'(4);
                    r_tag      <= r_fetch_pc;
                end
                if (w_push) r_tail <= r_tail + PW'(1);
                if (w_pop)  r_head <= r_head + PW'(1);
                if (w_push && !w_pop)      r_count <= r_count + CW'(1);
                else if (!w_push && w_pop) r_count <= r_count - CW'(1);
            end
        end
    end

    // Queue storage; contents are only visible through a non-zero count.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_q_pc[r_tail]   <= r_tag;
            r_q_inst[r_tail] <= bus.imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: memory returns word = address.
module tb_fetch_queue;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   passed = 0;

    always #5 clock = ~clock;

    fetch_queue_if #(.ADDRESS_BITS(16)) bus ();

    fetch_queue #(
        .ADDRESS_BITS(16),
        .RESET_PC    (16'h0000),
        .DEPTH       (2),
        .NOP         (NOP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // Fixed one-cycle-latency instruction memory; garbage when not requested.
    always @(posedge clock)
        bus.imem_rdata <= bus.imem_req ? 32'(bus.imem_addr) : 32'hDEADBEEF;

    typedef struct {
        logic        rst_n;
        logic        ready;
        logic        sel;
        logic [15:0] tgt;
        logic        e_valid;
        logic [15:0] e_pc;
        logic [31:0] e_inst;
        logic        e_req;
        logic [15:0] e_addr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic rd, input logic s,
                                input logic [15:0] t, input logic v,
                                input logic [15:0] pc, input logic [31:0] ins,
                                input logic rq, input logic [15:0] a);
        vec_t x;
        x.rst_n = r;  x.ready = rd; x.sel = s;  x.tgt = t;
        x.e_valid = v; x.e_pc = pc; x.e_inst = ins; x.e_req = rq; x.e_addr = a;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [15:0] exp_pc;
        logic        found;

        bus.next_PC_select = 1'b0;
        bus.target_PC      = '0;
        bus.inst_ready     = 1'b1;

        // rst ready sel target | valid PC instruction req addr
        vecs.push_back(mk(0,1,0,16'h0000, 0,16'h0000,NOP,         0,16'h0000));
        vecs.push_back(mk(0,1,0,16'h0000, 0,16'h0000,NOP,         0,16'h0000));
        vecs.push_back(mk(1,1,0,16'h0000, 0,16'h0000,NOP,         0,16'h0000));
        vecs.push_back(mk(1,1,0,16'h0000, 0,16'h0000,NOP,         1,16'h0000));
        vecs.push_back(mk(1,1,0,16'h0000, 0,16'h0000,NOP,         1,16'h0004));
        // stall five cycles: head holds, issue stops after two reads
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0000,32'h0,       0,16'h0008));
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0000,32'h0,       0,16'h0008));
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0000,32'h0,       0,16'h0008));
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0000,32'h0,       0,16'h0008));
        vecs.push_back(mk(1,0,0,16'h0000, 1,16'h0000,32'h0,       0,16'h0008));
        vecs.push_back(mk(1,1,0,16'h0000, 1,16'h0000,32'h0,       1,16'h0008));
        vecs.push_back(mk(1,1,0,16'h0000, 1,16'h0004,32'h4,       1,16'h000C));
        vecs.push_back(mk(1,1,0,16'h0000, 1,16'h0008,32'h8,       1,16'h0010));
        vecs.push_back(mk(1,1,0,16'h0000, 1,16'h000C,32'hC,       1,16'h0014));
        // misaligned redirect with pop and response in the same cycle
        vecs.push_back(mk(1,1,1,16'h0157, 1,16'h0010,32'h10,      0,16'h0018));
        vecs.push_back(mk(1,1,0,16'h0000, 0,16'h0000,NOP,         1,16'h0154));
        vecs.push_back(mk(1,1,0,16'h0000, 0,16'h0000,NOP,         1,16'h0158));
        vecs.push_back(mk(1,1,0,16'h0000, 1,16'h0154,32'h154,     1,16'h015C));
        // redirect near the top of the address space: fetch PC wraps
        vecs.push_back(mk(1,1,1,16'hFFF8, 1,16'h0158,32'h158,     0,16'h0160));
        vecs.push_back(mk(1,1,0,16'h0000, 0,16'h0000,NOP,         1,16'hFFF8));
        vecs.push_back(mk(1,1,0,16'h0000, 0,16'h0000,NOP,         1,16'hFFFC));
        vecs.push_back(mk(1,1,0,16'h0000, 1,16'hFFF8,32'hFFF8,    1,16'h0000));
        vecs.push_back(mk(1,1,0,16'h0000, 1,16'hFFFC,32'hFFFC,    1,16'h0004));
        vecs.push_back(mk(1,1,0,16'h0000, 1,16'h0000,32'h0,       1,16'h0008));

        step();
        foreach (vecs[i]) begin
            reset              = vecs[i].rst_n;
            bus.inst_ready     = vecs[i].ready;
            bus.next_PC_select = vecs[i].sel;
            bus.target_PC      = vecs[i].tgt;
            #1;
            chk($sformatf("v%0d_valid", i), 32'(bus.inst_valid),  32'(vecs[i].e_valid));
            chk($sformatf("v%0d_pc",    i), 32'(bus.PC),          32'(vecs[i].e_pc));
            chk($sformatf("v%0d_inst",  i), bus.instruction,      vecs[i].e_inst);
            chk($sformatf("v%0d_req",   i), 32'(bus.imem_req),    32'(vecs[i].e_req));
            chk($sformatf("v%0d_addr",  i), 32'(bus.imem_addr),   32'(vecs[i].e_addr));
            step();
        end
        bus.next_PC_select = 1'b0;

        // Stream from reset up to PC 0x0114, checking the sequence on the way.
        reset = 1'b0;
        bus.inst_ready = 1'b1;
        step();
        reset = 1'b1;
        exp_pc = 16'h0000;
        found  = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            #1;
            if (bus.inst_valid) begin
                chk("seq_pc",   32'(bus.PC),      32'(exp_pc));
                chk("seq_inst", bus.instruction,  32'(exp_pc));
                if (exp_pc == 16'h0114) found = 1'b1;
                else exp_pc = exp_pc + 16'h4;
            end
            if (!found) step();
        end
        chk("reach_0114", 32'(found), 32'h1);

        // Redirect to 0x0128 while 0x0118 is returning and 0x0114 is popped.
        bus.next_PC_select = 1'b1;
        bus.target_PC      = 16'h0128;
        #1;
        chk("redir_req", 32'(bus.imem_req), 32'h0);
        step();
        bus.next_PC_select = 1'b0;
        bus.target_PC      = '0;
        #1;
        chk("redir_r1_valid", 32'(bus.inst_valid), 32'h0);
        chk("redir_r1_addr",  32'(bus.imem_addr),  32'h0128);
        step(); #1;
        chk("redir_r2_valid", 32'(bus.inst_valid), 32'h0);
        step(); #1;
        chk("redir_r3_valid", 32'(bus.inst_valid), 32'h1);
        chk("redir_r3_pc",    32'(bus.PC),         32'h0128);
        chk("redir_r3_inst",  bus.instruction,     32'h0128);
        step(); #1;
        chk("redir_r4_pc",    32'(bus.PC),         32'h012C);

        // Asynchronous reset mid-stream: outputs clear with no clock edge.
        #1;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.inst_valid), 32'h0);
        chk("arst_inst",  bus.instruction,     NOP);
        chk("arst_pc",    32'(bus.PC),         32'h0);
        chk("arst_req",   32'(bus.imem_req),   32'h0);
        chk("arst_addr",  32'(bus.imem_addr),  32'h0);
        step();
        reset = 1'b1;
        step(); step(); #1;
        chk("arst_c2_valid", 32'(bus.inst_valid), 32'h0);
        step(); #1;
        chk("arst_c3_valid", 32'(bus.inst_valid), 32'h1);
        chk("arst_c3_pc",    32'(bus.PC),         32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end by itself");
        $fatal(1);
    end
endmodule
